// File: rtl/seg_bcd_display.sv
// Sequential double-dabble seven-segment driver. It snapshots CHANNELS binary values and
// converts them one channel at a time into registered active-low gfedcba digit codes.

module seg_bcd_digit (
  input  logic [3:0] nib,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b1111111;
    if (dash) seg = 7'b0111111;
    else if (!blank) begin
      case (nib)
        4'd0:    seg = 7'b1000000;
        4'd1:    seg = 7'b1111001;
        4'd2:    seg = 7'b0100100;
        4'd3:    seg = 7'b0110000;
        4'd4:    seg = 7'b0011001;
        4'd5:    seg = 7'b0010010;
        4'd6:    seg = 7'b0000010;
        4'd7:    seg = 7'b1111000;
        4'd8:    seg = 7'b0000000;
        4'd9:    seg = 7'b0010000;
        default: seg = 7'b1111111;
      endcase
    end
  end
endmodule

module seg_bcd_display #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 2,
  parameter int BLANK_LZ = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CHANNELS*WIDTH-1:0]    in_data,
  input  logic                         update,
  output logic                         busy,
  output logic                         done,
  output logic [CHANNELS*DIGITS*7-1:0] hex,
  output logic [CHANNELS-1:0]          overflow
);
  // ceil(WIDTH*log10(2)) nibbles hold any WIDTH-bit value
  localparam int NI_MIN = (WIDTH * 30103 + 99999) / 100000;
  localparam int NI     = (DIGITS > NI_MIN) ? DIGITS : NI_MIN;
  localparam int BW     = 4 * NI;
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SC_W   = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_STORE} state_t;
  state_t state, state_nxt;

  logic [CHANNELS-1:0][WIDTH-1:0]        snap;
  logic [CH_W-1:0]                       ch_idx;
  logic [SC_W-1:0]                       sh_cnt;
  logic [WIDTH-1:0]                      bin_q, cur_val;
  logic [BW-1:0]                         bcd_q, bcd_adj;
  logic [CHANNELS-1:0][DIGITS-1:0][6:0]  hex_q;
  logic [CHANNELS-1:0]                   ovf_q;
  logic [DIGITS-1:0][6:0]                seg_w;
  logic [DIGITS-1:0]                     blank_w;
  logic                                  ovf_w, last_ch, last_bit;

  assign last_ch  = (ch_idx == CH_W'(CHANNELS - 1));
  assign last_bit = (sh_cnt == SC_W'(WIDTH - 1));
  assign busy     = (state != S_IDLE);
  assign hex      = hex_q;
  assign overflow = ovf_q;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (update) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_SHIFT;
      S_SHIFT: if (last_bit) state_nxt = S_STORE;
      S_STORE: state_nxt = last_ch ? S_IDLE : S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cur_val = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (ch_idx == CH_W'(c)) cur_val = snap[c];
  end

  // add-3 correction applied before every shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < NI; n++)
      if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
  end

  generate
    if (NI > DIGITS) begin : g_ovf
      assign ovf_w = |bcd_q[BW-1:4*DIGITS];
    end else begin : g_no_ovf
      assign ovf_w = 1'b0;
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
      if (d == 0) begin : g_d0
        assign blank_w[d] = 1'b0;
      end else begin : g_dn
        assign blank_w[d] = (BLANK_LZ != 0) && (bcd_q[4*DIGITS-1:4*d] == '0);
      end
      seg_bcd_digit u_dig (
        .nib   (bcd_q[4*d +: 4]),
        .blank (blank_w[d]),
        .dash  (ovf_w),
        .seg   (seg_w[d])
      );
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      snap   <= '0;
      ch_idx <= '0;
      sh_cnt <= '0;
      bin_q  <= '0;
      bcd_q  <= '0;
      hex_q  <= '1;
      ovf_q  <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (update) begin
            snap   <= in_data;
            ch_idx <= '0;
          end
        end
        S_LOAD: begin
          bin_q  <= cur_val;
          bcd_q  <= '0;
          sh_cnt <= '0;
        end
        S_SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          sh_cnt         <= sh_cnt + 1'b1;
        end
        S_STORE: begin
          for (int c = 0; c < CHANNELS; c++) begin
            if (ch_idx == CH_W'(c)) begin
              hex_q[c] <= seg_w;
              ovf_q[c] <= ovf_w;
            end
          end
          ch_idx <= ch_idx + 1'b1;
          if (last_ch) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
